// File: rtl/parity_rx_checker.sv
// rtl/parity_rx_checker.sv - serial even-parity frame receiver and checker
// Deserialises DATA_W data bits (LSB first) plus one parity bit and counts parity failures.
module parity_rx_checker #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              acc;
  logic [DATA_W-1:0] shreg;
  logic              bad;

  // Parity verdict for the bit currently on the line, only used in S_PAR.
  assign bad = acc ^ bit_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_DATA;
      cnt         <= '0;
      acc         <= 1'b0;
      shreg       <= '0;
      data_out    <= '0;
      parity_err  <= 1'b0;
      frame_valid <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (clear) begin
        state <= S_DATA;
        cnt   <= '0;
        acc   <= 1'b0;
        shreg <= '0;
      end else if (bit_valid) begin
        case (state)
          S_DATA: begin
            shreg[cnt] <= bit_in;
            acc        <= acc ^ bit_in;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_PAR;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_PAR: begin
            data_out    <= shreg;
            parity_err  <= bad;
            frame_valid <= 1'b1;
            if (bad && (err_count != CNT_MAX)) begin
              err_count <= err_count + CNT_W'(1);
            end
            cnt   <= '0;
            acc   <= 1'b0;
            state <= S_DATA;
          end
          default: state <= S_DATA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_rx_checker.sv
// tb/tb_parity_rx_checker.sv - randomized self-checking bench for parity_rx_checker
// A queue-based frame model predicts outputs of a default instance and a CNT_W=2 instance.
module tb_parity_rx_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic clear = 1'b0;

  logic [15:0] data_out, data_out_s;
  logic        frame_valid, frame_valid_s;
  logic        parity_err, parity_err_s;
  logic [7:0]  err_count;
  logic [1:0]  err_count_s;

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit          q[$];
  logic [15:0] m_data = '0;
  logic        m_perr = 1'b0;
  logic        m_fv = 1'b0;
  int          m_nbad = 0;
  bit          model_live = 1'b0;

  always #5 clk = ~clk;

  parity_rx_checker #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .data_out(data_out), .frame_valid(frame_valid), .parity_err(parity_err),
    .err_count(err_count)
  );

  parity_rx_checker #(.DATA_W(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .data_out(data_out_s), .frame_valid(frame_valid_s), .parity_err(parity_err_s),
    .err_count(err_count_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cnt8();
    return (m_nbad > 255) ? 8'd255 : 8'(m_nbad);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (m_nbad > 3) ? 2'd3 : 2'(m_nbad);
  endfunction

  // One clock cycle: apply inputs, let the edge happen, advance the model.
  task automatic step(input logic r, input logic c, input logic v, input logic b);
    logic [15:0] d;
    rst = r; clear = c; bit_valid = v; bit_in = b;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_data = '0; m_perr = 1'b0; m_fv = 1'b0; m_nbad = 0;
    end else begin
      m_fv = 1'b0;
      if (c) begin
        q.delete();
      end else if (v) begin
        q.push_back(b);
        if (q.size() == 17) begin
          d = '0;
          for (int i = 0; i < 16; i++) d[i] = q[i];
          m_data = d;
          m_perr = (^d) ^ q[16];
          m_fv = 1'b1;
          if (m_perr) m_nbad++;
          q.delete();
        end
      end
    end
    model_live = 1'b1;
    #1;
  endtask

  task automatic send_frame(input logic [15:0] d, input logic p, input int gap);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b0, 1'b1, (i < 16) ? d[i] : p);
      if (i < 16) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'($urandom));
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
      chk("err_count", 32'(err_count), 32'(exp_cnt8()));
      chk("sat_frame_valid", 32'(frame_valid_s), 32'(m_fv));
      chk("sat_data_out", 32'(data_out_s), 32'(m_data));
      chk("sat_parity_err", 32'(parity_err_s), 32'(m_perr));
      chk("sat_err_count", 32'(err_count_s), 32'(exp_cnt2()));
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_fv", 32'(frame_valid), 32'h0);
    chk("reset_cnt", 32'(err_count), 32'h0);

    send_frame(16'h0000, 1'b0, 0);
    chk("f0_fv", 32'(frame_valid), 32'h1);
    chk("f0_data", 32'(data_out), 32'h0000);
    chk("f0_perr", 32'(parity_err), 32'h0);
    chk("f0_cnt", 32'(err_count), 32'h0);

    send_frame(16'hA5A5, 1'b1, 0);
    chk("a5_data", 32'(data_out), 32'hA5A5);
    chk("a5_perr", 32'(parity_err), 32'h1);
    chk("a5_cnt", 32'(err_count), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_fv_drop", 32'(frame_valid), 32'h0);

    send_frame(16'h0001, 1'b1, 3);
    chk("gap_fv", 32'(frame_valid), 32'h1);
    chk("gap_data", 32'(data_out), 32'h0001);
    chk("gap_perr", 32'(parity_err), 32'h0);
    chk("gap_cnt", 32'(err_count), 32'h1);

    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom));
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_hold_data", 32'(data_out), 32'h0001);
    send_frame(16'h8000, 1'b1, 0);
    chk("clr_data", 32'(data_out), 32'h8000);
    chk("clr_perr", 32'(parity_err), 32'h0);
    chk("clr_cnt", 32'(err_count), 32'h1);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_cnt", 32'(err_count), 32'h0);
    send_frame(16'hFFFF, 1'b0, 0);
    chk("ffff_data", 32'(data_out), 32'hFFFF);
    chk("ffff_perr", 32'(parity_err), 32'h0);

    for (int n = 1; n <= 5; n++) begin
      send_frame(16'(n * 16'h1357), ~(^(16'(n * 16'h1357))), 0);
      chk("sat_cnt", 32'(err_count_s), 32'((n > 3) ? 3 : n));
      chk("sat_perr", 32'(parity_err_s), 32'h1);
      chk("sat_fv", 32'(frame_valid_s), 32'h1);
      chk("wide_cnt", 32'(err_count), 32'(n));
    end

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
